// File: rtl/sync_prefetch_fifo.sv
// Single-clock first-word-fall-through FIFO: RAM of 2^DEPTH_WIDTH-1 words
// with registered read feeding one output register; all outputs registered.
module sync_prefetch_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10,
    parameter int AFULL_TH    = (1 << DEPTH_WIDTH) - 4,
    parameter int AEMPTY_TH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_vld,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DEPTH_WIDTH:0]   level,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int LP_RAM = (1 << DEPTH_WIDTH) - 1;
    localparam logic [DEPTH_WIDTH:0]   LP_CAP  = (DEPTH_WIDTH+1)'(1 << DEPTH_WIDTH);
    localparam logic [DEPTH_WIDTH:0]   LP_AF   = (DEPTH_WIDTH+1)'(AFULL_TH);
    localparam logic [DEPTH_WIDTH:0]   LP_AE   = (DEPTH_WIDTH+1)'(AEMPTY_TH);
    localparam logic [DEPTH_WIDTH-1:0] LP_LAST = DEPTH_WIDTH'(LP_RAM - 1);

    logic [DATA_WIDTH-1:0]  r_mem [LP_RAM];
    logic [DEPTH_WIDTH-1:0] r_wptr;
    logic [DEPTH_WIDTH-1:0] r_rptr;
    logic [DEPTH_WIDTH:0]   r_level;
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic                   r_rd_vld;
    logic                   r_wr_vld;
    logic                   r_afull;
    logic                   r_aempty;
    logic                   r_ovf;
    logic                   r_udf;

    logic                   w_wr;
    logic                   w_pop;
    logic [DEPTH_WIDTH:0]   w_ram_cnt;
    logic                   w_ram_has;
    logic                   w_load_ram;
    logic                   w_bypass;
    logic                   w_ram_we;
    logic [DEPTH_WIDTH:0]   w_level_nxt;

    function automatic logic [DEPTH_WIDTH-1:0] f_inc(input logic [DEPTH_WIDTH-1:0] p);
        return (p == LP_LAST) ? '0 : p + DEPTH_WIDTH'(1);
    endfunction

    // Words behind the output register live in RAM; the head word refills
    // from RAM on a pop, or takes wr_data directly when RAM is empty.
    always_comb begin
        w_wr        = wr_en & r_wr_vld;
        w_pop       = rd_en & r_rd_vld;
        w_ram_cnt   = r_level - {{DEPTH_WIDTH{1'b0}}, r_rd_vld};
        w_ram_has   = (w_ram_cnt != '0);
        w_load_ram  = w_pop & w_ram_has;
        w_bypass    = w_wr & (~r_rd_vld | (w_pop & ~w_ram_has));
        w_ram_we    = w_wr & ~w_bypass & ~flush;
        w_level_nxt = r_level + {{DEPTH_WIDTH{1'b0}}, w_wr}
                              - {{DEPTH_WIDTH{1'b0}}, w_pop};
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_afull   <= 1'b0;
            r_aempty  <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else if (flush) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_rd_vld  <= 1'b0;
            r_wr_vld  <= 1'b1;
            r_afull   <= (LP_AF == '0);
            r_aempty  <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_level  <= w_level_nxt;
            r_wr_vld <= (w_level_nxt < LP_CAP);
            r_afull  <= (w_level_nxt >= LP_AF);
            r_aempty <= (w_level_nxt <= LP_AE);
            if (wr_en && !r_wr_vld) begin
                r_ovf <= 1'b1;
            end
            if (rd_en && !r_rd_vld) begin
                r_udf <= 1'b1;
            end
            if (w_ram_we) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_load_ram) begin
                r_rd_data <= r_mem[r_rptr];
                r_rptr    <= f_inc(r_rptr);
            end else if (w_bypass) begin
                r_rd_data <= wr_data;
            end
            if (w_load_ram || w_bypass) begin
                r_rd_vld <= 1'b1;
            end else if (w_pop) begin
                r_rd_vld <= 1'b0;
            end
        end
    end

    assign wr_vld       = r_wr_vld;
    assign rd_vld       = r_rd_vld;
    assign rd_data      = r_rd_data;
    assign level        = r_level;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_prefetch_fifo.sv
// Directed bench for sync_prefetch_fifo at default parameters.
module tb_sync_prefetch_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic        wr_vld;
    logic        rd_vld;
    logic [31:0] rd_data;
    logic [10:0] level;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    int n_vec = 0;
    int n_err = 0;

    sync_prefetch_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_vld       (wr_vld),
        .rd_en        (rd_en),
        .rd_vld       (rd_vld),
        .rd_data      (rd_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act,
                            input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_level"}, level, 0);
        check_eq({tag, "_rdvld"}, rd_vld, 0);
        check_eq({tag, "_wrvld"}, wr_vld, 0);
        check_eq({tag, "_afull"}, almost_full, 0);
        check_eq({tag, "_aempty"}, almost_empty, 1);
        check_eq({tag, "_ovf"}, overflow, 0);
        check_eq({tag, "_udf"}, underflow, 0);
        check_eq({tag, "_rdata"}, rd_data, 0);
    endtask

    initial begin
        #12;
        check_reset_vals("rst");
        rst_n = 1'b1;
        #1;
        check_eq("wrvld_pre_edge", wr_vld, 0);
        tick();
        check_eq("wrvld_post_edge", wr_vld, 1);

        // First-word bypass into an empty FIFO
        push(32'hA5A5_0001);
        check_eq("fwft_vld", rd_vld, 1);
        check_eq("fwft_data", rd_data, 32'hA5A5_0001);
        check_eq("fwft_level", level, 1);
        tick();
        check_eq("hold_data", rd_data, 32'hA5A5_0001);
        pop();
        check_eq("pop1_vld", rd_vld, 0);
        check_eq("pop1_level", level, 0);

        pop();
        check_eq("udf_set", underflow, 1);
        check_eq("udf_level", level, 0);
        check_eq("udf_vld", rd_vld, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("udf_clr", underflow, 0);

        // Write and pop together at level 1
        push(32'h11);
        wr_en = 1'b1; wr_data = 32'h22; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_eq("l1_vld", rd_vld, 1);
        check_eq("l1_data", rd_data, 32'h22);
        check_eq("l1_level", level, 1);
        push(32'h33);
        pop();
        check_eq("l2_pop_data", rd_data, 32'h33);
        check_eq("l2_pop_vld", rd_vld, 1);
        pop();
        check_eq("l2_empty", level, 0);

        // Fill to capacity
        for (int i = 0; i < 1024; i++) begin
            push(32'h1000 + i);
            if (i == 1018) check_eq("afull_1019", almost_full, 0);
            if (i == 1019) check_eq("afull_1020", almost_full, 1);
        end
        check_eq("full_wrvld", wr_vld, 0);
        check_eq("full_level", level, 1024);
        check_eq("full_afull", almost_full, 1);
        check_eq("full_ovf0", overflow, 0);
        push(32'hDEAD);
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_level", level, 1024);
        wr_en = 1'b1; wr_data = 32'hBEEF; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_eq("fullpop_level", level, 1023);
        check_eq("fullpop_wrvld", wr_vld, 1);
        for (int i = 1; i < 1024; i++) begin
            check_eq("drain_data", rd_data, 32'h1000 + i);
            pop();
            if (i == 1018) check_eq("aempty_5", almost_empty, 0);
            if (i == 1019) check_eq("aempty_4", almost_empty, 1);
        end
        check_eq("drained_vld", rd_vld, 0);
        check_eq("drained_level", level, 0);
        check_eq("ovf_sticky", overflow, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("ovf_clr", overflow, 0);

        // Sustained write+pop at level 5, pointers wrap several times
        for (int k = 0; k < 5; k++) push(32'h2000 + k);
        for (int c = 0; c < 3000; c++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h2005 + c;
            check_eq("stream_data", rd_data, 32'h2000 + c);
            tick();
            check_eq("stream_level", level, 5);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("stream_tail", rd_data, 32'h2000 + 3000 + k);
            pop();
        end
        check_eq("stream_empty", level, 0);

        // Flush beats a simultaneous write
        for (int k = 0; k < 3; k++) push(32'h50 + k);
        check_eq("pre_flush_level", level, 3);
        flush = 1'b1; wr_en = 1'b1; wr_data = 32'h99;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check_eq("flush_level", level, 0);
        check_eq("flush_vld", rd_vld, 0);
        check_eq("flush_ovf", overflow, 0);
        check_eq("flush_wrvld", wr_vld, 1);
        push(32'h55);
        check_eq("post_flush_data", rd_data, 32'h55);
        check_eq("post_flush_level", level, 1);
        pop();

        // Asynchronous reset in the middle of a burst
        wr_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wr_data = 32'h3000 + i;
            tick();
        end
        check_eq("burst_level", level, 200);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("rel_vld", rd_vld, 0);
        check_eq("rel_level", level, 0);
        check_eq("rel_wrvld", wr_vld, 1);
        push(32'h4444);
        check_eq("rel_data", rd_data, 32'h4444);
        check_eq("rel_level1", level, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
